// File: rtl/cm0_mtx_addr_decoder.sv
// AHB-Lite address decoder and slave-response multiplexer for the cm0 bus
// matrix output stage. It decodes the address phase into slave selects,
// tracks the data-phase owner and muxes its response back to the master.
// It also holds a sticky record of the first errored transfer.
module cm0_mtx_addr_decoder #(
  parameter int unsigned                 NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*4-1:0]     SLV_REGION = 16'h3210
) (
  input  logic                           HCLK,
  input  logic                           HRESET,
  input  logic [31:0]                    HADDR,
  input  logic [1:0]                     HTRANS,
  output logic [NUM_SLAVES-1:0]          HSELS,
  output logic                           HSELDEF,
  input  logic [NUM_SLAVES-1:0]          HREADYOUTS,
  input  logic [2*NUM_SLAVES-1:0]        HRESPS,
  input  logic [32*NUM_SLAVES-1:0]       HRDATAS,
  input  logic                           HREADYOUTDEF,
  input  logic [1:0]                     HRESPDEF,
  output logic                           HREADY,
  output logic [1:0]                     HRESP,
  output logic [31:0]                    HRDATA,
  input  logic                           ERRCLR,
  output logic                           ERRVALID,
  output logic                           ERROVF,
  output logic [31:0]                    ERRADDR
);

  localparam int unsigned DSEL_W   = NUM_SLAVES + 1;
  localparam int unsigned DEF_IDX  = NUM_SLAVES;
  localparam logic [1:0]  RESP_ERR = 2'b01;

  logic [NUM_SLAVES-1:0] w_hsels;
  logic                  w_found;
  logic                  w_ready;
  logic [1:0]            w_resp;
  logic [31:0]           w_rdata;
  logic                  w_err_ev;
  logic                  w_unused_htrans0;

  logic [DSEL_W-1:0]     r_dsel;
  logic [31:0]           r_addr_dp;
  logic                  r_act_dp;
  logic                  r_errvalid;
  logic                  r_errovf;
  logic [31:0]           r_erraddr;

  // HTRANS[0] only separates NONSEQ from SEQ; an active transfer is bit 1 alone
  assign w_unused_htrans0 = HTRANS[0];

  // Address-phase decode: the lowest-indexed matching region wins
  always_comb begin
    w_hsels = '0;
    w_found = 1'b0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (!w_found && (HADDR[31:28] == SLV_REGION[i*4 +: 4])) begin
        w_hsels[i] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

  assign HSELS   = w_hsels;
  assign HSELDEF = ~w_found;

  // Data-phase owner and address; both advance only when the bus is ready
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_dsel    <= DSEL_W'(1) << DEF_IDX;
      r_addr_dp <= '0;
      r_act_dp  <= 1'b0;
    end else if (HREADY) begin
      r_dsel    <= {~w_found, w_hsels};
      r_addr_dp <= HADDR;
      r_act_dp  <= HTRANS[1];
    end
  end

  // Response mux: default slave unless a mapped slave owns the data phase
  always_comb begin
    w_ready = HREADYOUTDEF;
    w_resp  = HRESPDEF;
    w_rdata = '0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (r_dsel[i]) begin
        w_ready = HREADYOUTS[i];
        w_resp  = HRESPS[i*2 +: 2];
        w_rdata = HRDATAS[i*32 +: 32];
      end
    end
  end

  assign HREADY = w_ready;
  assign HRESP  = w_resp;
  assign HRDATA = w_rdata;

  // Final cycle of a two-cycle ERROR response to an active transfer
  assign w_err_ev = w_ready & (w_resp == RESP_ERR) & r_act_dp;

  // Sticky error capture; a clear in the same cycle as an error yields a fresh capture
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_errvalid <= 1'b0;
      r_errovf   <= 1'b0;
      r_erraddr  <= '0;
    end else begin
      if (ERRCLR) begin
        r_errvalid <= 1'b0;
        r_errovf   <= 1'b0;
      end
      if (w_err_ev) begin
        if (!r_errvalid || ERRCLR) begin
          r_errvalid <= 1'b1;
          r_erraddr  <= r_addr_dp;
        end else begin
          r_errovf   <= 1'b1;
        end
      end
    end
  end

  assign ERRVALID = r_errvalid;
  assign ERROVF   = r_errovf;
  assign ERRADDR  = r_erraddr;

endmodule
